// File: rtl/alu_exec_pipe.sv
// Pipelined register-file + ALU execute block.
// One issue stage (valid/ready), one execute/writeback stage with result forwarding,
// and an iterative shift-add multiplier that holds off issue while it runs.
module alu_exec_pipe #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [3:0]               ALUctrl,
  input  logic [DATA_WIDTH-1:0]    immOp,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic [DATA_WIDTH-1:0]    ALUout,
  output logic                     EQ,
  output logic                     out_valid
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CW    = $clog2(DATA_WIDTH);

  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR  = A0_INDEX[ADDRESS_WIDTH-1:0];
  localparam logic [CW-1:0]            CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSltu = 4'd6;
  localparam logic [3:0] OpSll  = 4'd7;
  localparam logic [3:0] OpSrl  = 4'd8;
  localparam logic [3:0] OpSra  = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  logic [DATA_WIDTH-1:0]    r_regs [DEPTH];
  state_e                   r_state;
  logic                     r_ex_valid;
  logic [DATA_WIDTH-1:0]    r_op1;
  logic [DATA_WIDTH-1:0]    r_op2;
  logic [3:0]               r_ctrl;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic                     r_we;
  logic [CW-1:0]            r_cnt;
  logic [DATA_WIDTH-1:0]    r_acc;
  logic [DATA_WIDTH-1:0]    r_mcand;
  logic [DATA_WIDTH-1:0]    r_mplier;
  logic [DATA_WIDTH-1:0]    r_alu_out;
  logic                     r_eq;
  logic                     r_out_valid;

  logic                     w_accept;
  logic                     w_wb_fire;
  logic [DATA_WIDTH-1:0]    w_wb_data;
  logic [DATA_WIDTH-1:0]    w_alu;
  logic [DATA_WIDTH-1:0]    w_mul_step;
  logic [CW-1:0]            w_shamt;
  logic                     w_fwd1;
  logic                     w_fwd2;
  logic [DATA_WIDTH-1:0]    w_op1;
  logic [DATA_WIDTH-1:0]    w_rd2;
  logic [DATA_WIDTH-1:0]    w_op2;

  assign in_ready  = (r_state == StIdle);
  assign w_accept  = in_valid && in_ready;
  assign a0        = r_regs[A0_ADDR];
  assign ALUout    = r_alu_out;
  assign EQ        = r_eq;
  assign out_valid = r_out_valid;

  // A single-cycle op retires on the edge after issue; a MUL retires on its last step.
  assign w_wb_fire  = r_ex_valid && ((r_state == StIdle) || (r_cnt == CNT_LAST));
  assign w_mul_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_wb_data  = (r_state == StMul) ? w_mul_step : w_alu;
  assign w_shamt    = r_op2[CW-1:0];

  // Single-cycle ALU result from the captured EX operands.
  always_comb begin
    w_alu = r_op1 + r_op2;
    case (r_ctrl)
      OpAdd:   w_alu = r_op1 + r_op2;
      OpSub:   w_alu = r_op1 - r_op2;
      OpAnd:   w_alu = r_op1 & r_op2;
      OpOr:    w_alu = r_op1 | r_op2;
      OpXor:   w_alu = r_op1 ^ r_op2;
      OpSlt:   w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(r_op1) < $signed(r_op2))};
      OpSltu:  w_alu = {{(DATA_WIDTH-1){1'b0}}, (r_op1 < r_op2)};
      OpSll:   w_alu = r_op1 << w_shamt;
      OpSrl:   w_alu = r_op1 >> w_shamt;
      OpSra:   w_alu = $signed(r_op1) >>> w_shamt;
      default: w_alu = r_op1 + r_op2;
    endcase
  end

  // Operand fetch with bypass of the result retiring on this same edge.
  always_comb begin
    w_fwd1 = w_wb_fire && r_we && (r_rd != '0) && (r_rd == rs1);
    w_fwd2 = w_wb_fire && r_we && (r_rd != '0) && (r_rd == rs2);
    w_op1  = '0;
    w_rd2  = '0;
    if (rs1 != '0) w_op1 = w_fwd1 ? w_wb_data : r_regs[rs1];
    if (rs2 != '0) w_rd2 = w_fwd2 ? w_wb_data : r_regs[rs2];
    w_op2  = ALUsrc ? immOp : w_rd2;
  end

  // Register file write port; x0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_regs[i] <= '0;
    end else if (w_wb_fire && r_we && (r_rd != '0)) begin
      r_regs[r_rd] <= w_wb_data;
    end
  end

  // Issue/EX FSM: captures accepted instructions, runs the multiplier, registers results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ex_valid  <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_ctrl      <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_alu_out   <= '0;
      r_eq        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_wb_fire;
      if (w_wb_fire) begin
        r_alu_out <= w_wb_data;
        r_eq      <= (r_op1 == r_op2);
      end
      case (r_state)
        StIdle: begin
          r_ex_valid <= w_accept;
          if (w_accept) begin
            r_op1  <= w_op1;
            r_op2  <= w_op2;
            r_ctrl <= ALUctrl;
            r_rd   <= rd;
            r_we   <= RegWrite;
            if (ALUctrl == OpMul) begin
              r_state  <= StMul;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= w_op1;
              r_mplier <= w_op2;
            end
          end
        end
        StMul: begin
          if (r_cnt == CNT_LAST) begin
            r_state    <= StIdle;
            r_ex_valid <= 1'b0;
          end else begin
            r_acc    <= w_mul_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Randomised + directed bench for alu_exec_pipe against a sequential ISA-level model.
module tb_alu_exec_pipe;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        RegWrite;
  logic        ALUsrc;
  logic [3:0]  ALUctrl;
  logic [31:0] immOp;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] a0;
  logic [31:0] ALUout;
  logic        EQ;
  logic        out_valid;

  alu_exec_pipe #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RegWrite  (RegWrite),
    .ALUsrc    (ALUsrc),
    .ALUctrl   (ALUctrl),
    .immOp     (immOp),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .a0        (a0),
    .ALUout    (ALUout),
    .EQ        (EQ),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural model: instructions take effect in issue order (what forwarding
  // guarantees); retirement into the visible file happens at the scheduled edge.
  typedef struct {
    int          due;
    logic [31:0] res;
    logic        eq;
    logic        we;
    int          rd;
  } wb_t;

  logic [31:0] arch [32];
  logic [31:0] comm [32];
  wb_t         wbq [$];
  int          cyc;
  int          busy_end;
  logic [31:0] exp_alu;
  logic        exp_eq;
  logic        exp_ov;

  function automatic logic [31:0] ref_alu(input int ctrl, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned p;
    int sh;
    sh = int'(b % 32);
    case (ctrl)
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:  return (a < b) ? 32'd1 : 32'd0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return $signed(a) >>> sh;
      10: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return a + b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      arch[i] = '0;
      comm[i] = '0;
    end
    wbq.delete();
    busy_end = 0;
    cyc      = 0;
    exp_alu  = '0;
    exp_eq   = 1'b0;
    exp_ov   = 1'b0;
  endtask

  // One clock: drive, check ready, take the edge, update the model, check outputs.
  task automatic cycle(input bit v, input bit we, input bit src, input int ctrl,
                       input logic [31:0] imm, input int s1, input int s2, input int d,
                       output bit acc);
    bit          ready_m;
    logic [31:0] a, b, r;
    wb_t         e;
    in_valid = v;
    RegWrite = we;
    ALUsrc   = src;
    ALUctrl  = ctrl[3:0];
    immOp    = imm;
    rs1      = s1[4:0];
    rs2      = s2[4:0];
    rd       = d[4:0];
    ready_m  = (cyc >= busy_end);
    #4;
    chk("in_ready", {31'd0, in_ready}, {31'd0, ready_m});
    acc = v && ready_m;
    @(posedge clk);
    #1;
    cyc++;
    exp_ov = 1'b0;
    if (wbq.size() > 0 && wbq[0].due == cyc) begin
      e = wbq.pop_front();
      if (e.we && e.rd != 0) comm[e.rd] = e.res;
      exp_alu = e.res;
      exp_eq  = e.eq;
      exp_ov  = 1'b1;
    end
    if (acc) begin
      a = (s1 == 0) ? 32'd0 : arch[s1];
      b = src ? imm : ((s2 == 0) ? 32'd0 : arch[s2]);
      r = ref_alu(ctrl, a, b);
      if (we && d != 0) arch[d] = r;
      e.due = cyc + ((ctrl == 10) ? DW : 1);
      e.res = r;
      e.eq  = (a == b);
      e.we  = we;
      e.rd  = d;
      wbq.push_back(e);
      if (ctrl == 10) busy_end = cyc + DW;
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("ALUout", ALUout, exp_alu);
    chk("EQ", {31'd0, EQ}, {31'd0, exp_eq});
    chk("a0", a0, comm[10]);
  endtask

  // Hold an instruction valid until accepted; reports how many edges it waited.
  task automatic send(input bit we, input bit src, input int ctrl, input logic [31:0] imm,
                      input int s1, input int s2, input int d, output int waits);
    bit acc;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 100) begin
      cycle(1'b1, we, src, ctrl, imm, s1, s2, d, acc);
      if (!acc) waits++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 32'd0, 0, 0, 0, acc);
  endtask

  // Idle until the model expects a writeback, then compare ALUout to a fixed value.
  task automatic drain_expect(input string tag, input logic [31:0] val);
    bit acc;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 32'd0, 0, 0, 0, acc);
      seen = exp_ov;
    end
    chk({tag, "_wb_seen"}, {31'd0, out_valid}, 32'd1);
    chk(tag, ALUout, val);
  endtask

  // Issue and wait for the result.
  task automatic op(input string tag, input bit src, input int ctrl, input logic [31:0] imm,
                    input int s1, input int s2, input int d, input logic [31:0] val);
    int w;
    send(1'b1, src, ctrl, imm, s1, s2, d, w);
    drain_expect(tag, val);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  acc;
    int  ctrl;
    rst      = 1'b1;
    in_valid = 1'b0;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = '0;
    immOp    = '0;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_a0", a0, 32'd0);
    chk("rst_ALUout", ALUout, 32'd0);
    chk("rst_EQ", {31'd0, EQ}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    op("rst_read_x7", 1'b1, 0, 32'd0, 7, 0, 8, 32'd0);

    // Back-to-back dependent adds rely on forwarding.
    send(1'b1, 1'b1, 0, 32'd5, 0, 0, 1, w);
    send(1'b1, 1'b1, 0, 32'd7, 1, 0, 2, w);
    idle(1);
    chk("fwd_add", ALUout, 32'd12);
    op("read_x2", 1'b1, 0, 32'd0, 2, 0, 9, 32'd12);

    op("addi_m1", 1'b1, 0, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFF);
    op("slt", 1'b0, 5, 32'd0, 1, 0, 3, 32'd1);
    op("sltu", 1'b0, 6, 32'd0, 1, 0, 4, 32'd0);
    op("sra", 1'b1, 9, 32'd4, 1, 0, 5, 32'hFFFF_FFFF);
    op("srl", 1'b1, 8, 32'd4, 1, 0, 6, 32'h0FFF_FFFF);
    op("sll36", 1'b1, 7, 32'd36, 1, 0, 7, 32'hFFFF_FFF0);

    // Multiply stalls issue for DW cycles; follow-up is held valid meanwhile.
    op("li_1234", 1'b1, 0, 32'd1234, 0, 0, 11, 32'd1234);
    op("li_5678", 1'b1, 0, 32'd5678, 0, 0, 12, 32'd5678);
    send(1'b1, 1'b0, 10, 32'd0, 11, 12, 10, w);
    send(1'b1, 1'b1, 0, 32'd0, 10, 0, 13, w);
    chk("mul_stall_cycles", w, 32'd32);
    chk("mul_a0", a0, 32'd7006652);
    drain_expect("mul_fwd_read", 32'd7006652);

    // Writes to x0 are dropped but still report a result.
    send(1'b1, 1'b1, 0, 32'd9, 0, 0, 0, w);
    idle(1);
    chk("x0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("x0_ALUout", ALUout, 32'd9);
    op("x0_read", 1'b1, 0, 32'd0, 0, 0, 14, 32'd0);

    // Random traffic; MUL is rarer to keep runtime short.
    for (int i = 0; i < 400; i++) begin
      ctrl = $urandom_range(0, 15);
      if (ctrl == 10 && $urandom_range(0, 3) != 0) ctrl = 0;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
            ctrl, $urandom(), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), acc);
    end
    idle(DW + 2);

    // Reset in the middle of a multiply aborts it.
    op("li_3", 1'b1, 0, 32'd3, 0, 0, 11, 32'd3);
    send(1'b1, 1'b1, 10, 32'd7, 11, 0, 10, w);
    idle(9);
    #1;
    rst = 1'b1;
    #1;
    chk("midmul_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midmul_ALUout", ALUout, 32'd0);
    chk("midmul_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midmul_a0", a0, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(DW + 4);
    chk("midmul_no_wb_a0", a0, 32'd0);
    op("midmul_read_x10", 1'b1, 0, 32'd0, 10, 0, 15, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
